bfp_normalize_16: RTL and testbench
===================================

// Module: bfp_normalize_16
// PURPOSE
//  Block-floating-point normaliser for the FFT datapath, directly downstream of the 16-input min-LZC detector.
//  Delays each 16-sample block until its minimum leading-sign-bit count arrives from the detector.
//  Left-shifts all 16 samples by a common, guarded and clamped amount, and tags the block with its shift.
//  Tracks the minimum shift over each FFT frame so the exponent-alignment stage can equalise blocks.
// PARAMETERS
//  DATA_WIDTH        16  signed sample width
//  LZC_WIDTH         5   width of LZC / shift values
//  MIN_LAT           1   en-cycles from detector input to its min_out (detector pipe depth)
//  GUARD_BITS        1   headroom bits kept after normalisation
//  MAX_SHIFT         15  upper clamp on shift (must be <= DATA_WIDTH-1)
//  BLOCKS_PER_FRAME  4   16-sample blocks per FFT frame (>=1)
// PORTS
//  clk               in   1            clock
//  rstn              in   1            asynchronous active-low reset
//  en                in   1            global pipeline enable, shared with the min detector
//  frame_clr         in   1            sync clear of frame counter and frame-min tracker
//  in_valid          in   1            in_data holds a block (same cycle the detector sees its LZCs)
//  in_data[0:15]     in   DATA_WIDTH   signed samples
//  min_lzc           in   LZC_WIDTH    detector min_out, valid MIN_LAT en-cycles after in_valid
//  out_valid         out  1            out_* hold a normalised block
//  out_data[0:15]    out  DATA_WIDTH   normalised samples
//  out_shift         out  LZC_WIDTH    shift applied to this block
//  out_last          out  1            block is the last of the frame
//  frame_shift       out  LZC_WIDTH    min shift over the completed frame
//  frame_shift_valid out  1            frame_shift valid (== out_valid & out_last)
// BEHAVIOUR
//  - Reset: all outputs 0; delay line cleared; blk_cnt=0; frame_min=MAX_SHIFT. Mid-operation reset drops in-flight blocks.
//  - en=0: every register holds, including outputs and the delay line.
//  - Consumers sample outputs only when en=1 and out_valid=1.
//  - Delay line: MIN_LAT en-qualified stages carry {in_valid, in_data}. Stage MIN_LAT aligns with min_lzc.
//  - Shift calc (comb, aligned cycle):
//      s = (min_lzc > GUARD_BITS) ? min_lzc - GUARD_BITS : 0
//      then clamp s to MAX_SHIFT.
//  - Output register (on en):
//      out_data[i] = aligned_data[i] <<< s, keeping the low DATA_WIDTH bits
//      out_shift = s; out_valid = aligned_valid
//      LZC counts redundant sign bits, so the shift cannot overflow.
//  - Latency: in_valid -> out_valid = MIN_LAT+1 en-cycles. Full throughput: one block per en-cycle, no bubbles needed.
//  - Invalid aligned slot: out_valid=0, out_last=0, frame_shift_valid=0; out_data/out_shift don't-care.
//  - Frame tracking, per valid aligned block, updated on en:
//      * last = (blk_cnt == BLOCKS_PER_FRAME-1).
//      * If last: blk_cnt->0; frame_shift=min(frame_min,s); frame_min->MAX_SHIFT.
//      * Otherwise: blk_cnt++; frame_min=min(frame_min,s).
//      * out_last=last & valid; frame_shift_valid=last & valid.
//      * frame_shift holds its value until the next frame completes.
//  - frame_clr (sampled on en=1 only):
//      * blk_cnt=0, frame_min=MAX_SHIFT.
//      * Takes priority over a simultaneous valid block: data still goes out, but the block is not counted.
//      * That block gets out_last=0 and frame_shift_valid=0.
//  - BLOCKS_PER_FRAME=1: every valid block is last; frame_shift=s.
//  - All-zero block: detector LZC=DATA_WIDTH-1, so shift = clamp(DATA_WIDTH-1-GUARD_BITS).
// TESTING
//  1. Reset: assert rstn=0 mid-stream -> all outputs 0 next cycle; after release, first out_valid exactly 2 en-cycles after in_valid.
//  2. Shift math (defaults): min_lzc=5 gives s=4, in_data=16'sh00F3 -> 16'sh0F30; min_lzc=1 gives s=0, data unchanged; min_lzc=0 gives s=0; min_lzc=20 gives s=15.
//  3. Sign: in_data=-3 (16'hFFFD), min_lzc=13 -> s=12, out_data=16'hD000; out_shift=12.
//  4. Frame: 4 back-to-back blocks with s=7,3,9,5 -> out_last and frame_shift_valid on the 4th only, frame_shift=3; next frame's tracking starts from 15.
//  5. Stall: toggle en 1,0,0,1 during a 4-block frame -> outputs frozen while en=0; no block lost or duplicated; frame_shift unchanged vs no-stall run.
//  6. frame_clr on the cycle block 2 of a frame is in the output stage -> that block out_last=0; the next 4 valid blocks form a new frame with correct frame_shift.

Source files
------------

// File: rtl/bfp_normalize_16.sv
`default_nettype none
// ============================================================================
//  Module      : bfp_normalize_16
//  Description : Block-floating-point normaliser for the FFT datapath. Delays
//                each 16-sample block until its min leading-sign-bit count
//                arrives from the detector, left-shifts every sample by a
//                guarded/clamped common amount, tags the block with the shift
//                and tracks the minimum shift across each FFT frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module bfp_normalize_16 #(
    parameter int DATA_WIDTH       = 16,
    parameter int LZC_WIDTH        = 5,
    parameter int MIN_LAT          = 1,   // detector pipe depth, must be >= 1
    parameter int GUARD_BITS       = 1,
    parameter int MAX_SHIFT        = 15,  // must be <= DATA_WIDTH-1
    parameter int BLOCKS_PER_FRAME = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_en,
    input  logic                         i_frame_clr,
    input  logic                         i_in_valid,
    input  logic signed [DATA_WIDTH-1:0] i_in_data [0:15],
    input  logic [LZC_WIDTH-1:0]         i_min_lzc,
    output logic                         o_out_valid,
    output logic signed [DATA_WIDTH-1:0] o_out_data [0:15],
    output logic [LZC_WIDTH-1:0]         o_out_shift,
    output logic                         o_out_last,
    output logic [LZC_WIDTH-1:0]         o_frame_shift,
    output logic                         o_frame_shift_valid
);

    localparam int CNT_W = (BLOCKS_PER_FRAME > 1) ? $clog2(BLOCKS_PER_FRAME) : 1;

    localparam logic [LZC_WIDTH-1:0] c_guard    = LZC_WIDTH'(GUARD_BITS);
    localparam logic [LZC_WIDTH-1:0] c_max      = LZC_WIDTH'(MAX_SHIFT);
    localparam logic [CNT_W-1:0]     c_last_cnt = CNT_W'(BLOCKS_PER_FRAME - 1);

    // Delay line: stage MIN_LAT-1 lines up with the detector's min_lzc
    logic                         r_dl_valid [0:MIN_LAT-1];
    logic signed [DATA_WIDTH-1:0] r_dl_data  [0:MIN_LAT-1][0:15];

    // Output stage registers
    logic                         r_out_valid;
    logic signed [DATA_WIDTH-1:0] r_out_data [0:15];
    logic [LZC_WIDTH-1:0]         r_out_shift;
    logic                         r_out_last;
    logic                         r_frame_shift_valid;

    // Frame tracking state
    logic [CNT_W-1:0]             r_blk_cnt;
    logic [LZC_WIDTH-1:0]         r_frame_min;
    logic [LZC_WIDTH-1:0]         r_frame_shift;

    logic                         w_al_valid;
    logic [LZC_WIDTH-1:0]         w_s_guarded;
    logic [LZC_WIDTH-1:0]         w_shift;
    logic [LZC_WIDTH-1:0]         w_min_s;
    logic                         w_count;
    logic                         w_is_last;
    logic signed [DATA_WIDTH-1:0] w_shifted [0:15];

    assign w_al_valid = r_dl_valid[MIN_LAT-1];

    // Guard headroom first, then clamp; the clamp also covers LZC values the
    // detector should never produce for a DATA_WIDTH-bit sample.
    assign w_s_guarded = (i_min_lzc > c_guard) ? (i_min_lzc - c_guard) : '0;
    assign w_shift     = (w_s_guarded > c_max) ? c_max : w_s_guarded;

    // frame_clr wins over a coincident valid block: it still goes out, uncounted
    assign w_count   = w_al_valid & ~i_frame_clr;
    assign w_is_last = w_count & (r_blk_cnt == c_last_cnt);
    assign w_min_s   = (w_shift < r_frame_min) ? w_shift : r_frame_min;

    // Per-lane barrel shift; the LZC guarantees no significant bits are lost
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lane
            assign w_shifted[gi] = r_dl_data[MIN_LAT-1][gi] <<< w_shift;
        end
    endgenerate

    // Delay line advances only on enable so it stays in step with the detector
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < MIN_LAT; k++) begin
                r_dl_valid[k] <= 1'b0;
                for (int j = 0; j < 16; j++) begin
                    r_dl_data[k][j] <= '0;
                end
            end
        end else if (i_en) begin
            r_dl_valid[0] <= i_in_valid;
            r_dl_data[0]  <= i_in_data;
            for (int k = 1; k < MIN_LAT; k++) begin
                r_dl_valid[k] <= r_dl_valid[k-1];
                r_dl_data[k]  <= r_dl_data[k-1];
            end
        end
    end

    // Output register: normalised samples, applied shift and frame tags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid         <= 1'b0;
            r_out_shift         <= '0;
            r_out_last          <= 1'b0;
            r_frame_shift_valid <= 1'b0;
            for (int j = 0; j < 16; j++) begin
                r_out_data[j] <= '0;
            end
        end else if (i_en) begin
            r_out_valid         <= w_al_valid;
            r_out_shift         <= w_shift;
            r_out_data          <= w_shifted;
            r_out_last          <= w_is_last;
            r_frame_shift_valid <= w_is_last;
        end
    end

    // Frame counter and running minimum shift; frame_shift holds between frames
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_blk_cnt     <= '0;
            r_frame_min   <= c_max;
            r_frame_shift <= '0;
        end else if (i_en) begin
            if (i_frame_clr) begin
                r_blk_cnt   <= '0;
                r_frame_min <= c_max;
            end else if (w_al_valid) begin
                if (w_is_last) begin
                    r_blk_cnt     <= '0;
                    r_frame_shift <= w_min_s;
                    r_frame_min   <= c_max;
                end else begin
                    r_blk_cnt   <= r_blk_cnt + CNT_W'(1);
                    r_frame_min <= w_min_s;
                end
            end
        end
    end

    assign o_out_valid         = r_out_valid;
    assign o_out_data          = r_out_data;
    assign o_out_shift         = r_out_shift;
    assign o_out_last          = r_out_last;
    assign o_frame_shift       = r_frame_shift;
    assign o_frame_shift_valid = r_frame_shift_valid;

endmodule
`default_nettype wire

// File: tb/tb_bfp_normalize_16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bfp_normalize_16
//  Description : Directed self-checking bench for bfp_normalize_16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bfp_normalize_16;

    logic               clk;
    logic               rstn;
    logic               en;
    logic               frame_clr;
    logic               in_valid;
    logic signed [15:0] in_data [0:15];
    logic [4:0]         min_lzc;
    logic               out_valid;
    logic signed [15:0] out_data [0:15];
    logic [4:0]         out_shift;
    logic               out_last;
    logic [4:0]         frame_shift;
    logic               frame_shift_valid;

    int total = 0;
    int bad   = 0;

    bfp_normalize_16 dut (
        .clk                 (clk),
        .rstn                (rstn),
        .i_en                (en),
        .i_frame_clr         (frame_clr),
        .i_in_valid          (in_valid),
        .i_in_data           (in_data),
        .i_min_lzc           (min_lzc),
        .o_out_valid         (out_valid),
        .o_out_data          (out_data),
        .o_out_shift         (out_shift),
        .o_out_last          (out_last),
        .o_frame_shift       (frame_shift),
        .o_frame_shift_valid (frame_shift_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle: lane i carries d+i; lzc is the detector result for the
    // block driven on the previous cycle. Returns 1 time unit after the edge.
    task automatic tick(input logic v, input logic [15:0] d, input logic [4:0] lzc,
                        input logic clr);
        in_valid  = v;
        min_lzc   = lzc;
        frame_clr = clr;
        for (int i = 0; i < 16; i++) in_data[i] = d + 16'(i);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b1;
        tick(1'b1, 16'h1234, 5'd9, 1'b0);
        tick(1'b1, 16'h1234, 5'd9, 1'b0);
        total++; if ({out_valid, out_last, frame_shift_valid} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {out_valid, out_last, frame_shift_valid}); end
        total++; if (out_shift !== 5'd0 || frame_shift !== 5'd0) begin bad++; $display("FAIL rst_shift: got %0d/%0d want 0/0", out_shift, frame_shift); end
        total++; if (out_data[0] !== 16'h0000 || out_data[15] !== 16'h0000) begin bad++; $display("FAIL rst_data: got %h/%h want 0000/0000", out_data[0], out_data[15]); end
        #3 rstn = 1'b1;
        tick(1'b1, 16'h0010, 5'd0, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early: got %b want 0", out_valid); end
        tick(1'b1, 16'h0010, 5'd3, 1'b0);
        total++; if (out_valid !== 1'b1 || out_data[0] !== 16'h0040 || out_shift !== 5'd2) begin bad++; $display("FAIL lat2: got v=%b d=%h s=%0d want v=1 d=0040 s=2", out_valid, out_data[0], out_shift); end
        // Mid-stream asynchronous reset while a block sits in the delay line
        #2 rstn = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_shift !== 5'd0 || out_data[0] !== 16'h0000) begin bad++; $display("FAIL rst_mid: got v=%b s=%0d d=%h want 0/0/0000", out_valid, out_shift, out_data[0]); end
        #1 rstn = 1'b1;
        tick(1'b0, 16'h0000, 5'd3, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_shift_math();
        tick(1'b0, 16'h0000, 5'd0, 1'b1);
        tick(1'b1, 16'h00F3, 5'd0, 1'b0);
        tick(1'b1, 16'h1234, 5'd5, 1'b0);
        total++; if (out_shift !== 5'd4 || out_data[0] !== 16'h0F30 || out_data[15] !== 16'h1020) begin bad++; $display("FAIL sh_lzc5: got s=%0d d0=%h d15=%h want 4/0F30/1020", out_shift, out_data[0], out_data[15]); end
        tick(1'b1, 16'h0055, 5'd1, 1'b0);
        total++; if (out_valid !== 1'b1 || out_shift !== 5'd0 || out_data[0] !== 16'h1234) begin bad++; $display("FAIL sh_lzc1: got v=%b s=%0d d=%h want 1/0/1234", out_valid, out_shift, out_data[0]); end
        tick(1'b1, 16'h0001, 5'd0, 1'b0);
        total++; if (out_shift !== 5'd0 || out_data[0] !== 16'h0055) begin bad++; $display("FAIL sh_lzc0: got s=%0d d=%h want 0/0055", out_shift, out_data[0]); end
        tick(1'b1, 16'h0001, 5'd20, 1'b0);
        total++; if (out_shift !== 5'd15 || out_data[0] !== 16'h8000 || out_data[1] !== 16'h0000) begin bad++; $display("FAIL sh_clamp: got s=%0d d0=%h d1=%h want 15/8000/0000", out_shift, out_data[0], out_data[1]); end
        tick(1'b0, 16'h0000, 5'd14, 1'b0);
        total++; if (out_shift !== 5'd13 || out_data[0] !== 16'h2000) begin bad++; $display("FAIL sh_lzc14: got s=%0d d=%h want 13/2000", out_shift, out_data[0]); end
        tick(1'b0, 16'h0000, 5'd0, 1'b0);
        total++; if (out_valid !== 1'b0 || out_last !== 1'b0 || frame_shift_valid !== 1'b0) begin bad++; $display("FAIL sh_idle: got %b%b%b want 000", out_valid, out_last, frame_shift_valid); end
    endtask

    task automatic test_sign();
        tick(1'b0, 16'h0000, 5'd0, 1'b1);
        tick(1'b1, 16'hFFFD, 5'd0, 1'b0);
        tick(1'b0, 16'h0000, 5'd13, 1'b0);
        total++; if (out_shift !== 5'd12 || out_data[0] !== 16'hD000 || out_data[1] !== 16'hE000) begin bad++; $display("FAIL sign: got s=%0d d0=%h d1=%h want 12/D000/E000", out_shift, out_data[0], out_data[1]); end
    endtask

    task automatic test_frame();
        tick(1'b0, 16'h0000, 5'd0, 1'b1);
        tick(1'b1, 16'h0001, 5'd0, 1'b0);
        tick(1'b1, 16'h0001, 5'd8, 1'b0);
        total++; if (out_shift !== 5'd7 || out_last !== 1'b0 || frame_shift_valid !== 1'b0) begin bad++; $display("FAIL fr_b1: got s=%0d l=%b fv=%b want 7/0/0", out_shift, out_last, frame_shift_valid); end
        tick(1'b1, 16'h0001, 5'd4, 1'b0);
        tick(1'b1, 16'h0001, 5'd10, 1'b0);
        total++; if (out_shift !== 5'd9 || out_last !== 1'b0) begin bad++; $display("FAIL fr_b3: got s=%0d l=%b want 9/0", out_shift, out_last); end
        tick(1'b1, 16'h0001, 5'd6, 1'b0);
        total++; if (out_shift !== 5'd5 || out_last !== 1'b1 || frame_shift_valid !== 1'b1 || frame_shift !== 5'd3) begin bad++; $display("FAIL fr_b4: got s=%0d l=%b fv=%b fs=%0d want 5/1/1/3", out_shift, out_last, frame_shift_valid, frame_shift); end
        // Second frame, shifts 12,13,14,12: minimum must restart from 15
        tick(1'b1, 16'h0001, 5'd13, 1'b0);
        total++; if (out_last !== 1'b0 || frame_shift_valid !== 1'b0 || frame_shift !== 5'd3) begin bad++; $display("FAIL fr_hold: got l=%b fv=%b fs=%0d want 0/0/3", out_last, frame_shift_valid, frame_shift); end
        tick(1'b1, 16'h0001, 5'd14, 1'b0);
        tick(1'b1, 16'h0001, 5'd15, 1'b0);
        tick(1'b0, 16'h0000, 5'd13, 1'b0);
        total++; if (out_last !== 1'b1 || frame_shift_valid !== 1'b1 || frame_shift !== 5'd12) begin bad++; $display("FAIL fr2_end: got l=%b fv=%b fs=%0d want 1/1/12", out_last, frame_shift_valid, frame_shift); end
    endtask

    task automatic test_stall();
        tick(1'b0, 16'h0000, 5'd0, 1'b1);
        tick(1'b1, 16'h0002, 5'd0, 1'b0);
        tick(1'b1, 16'h0003, 5'd7, 1'b0);
        total++; if (out_shift !== 5'd6 || out_data[0] !== 16'h0080) begin bad++; $display("FAIL st_b1: got s=%0d d=%h want 6/0080", out_shift, out_data[0]); end
        en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick(1'b1, 16'hAAAA, 5'd1, 1'b1);
            total++; if (out_valid !== 1'b1 || out_shift !== 5'd6 || out_data[0] !== 16'h0080 || out_last !== 1'b0) begin bad++; $display("FAIL st_hold%0d: got v=%b s=%0d d=%h l=%b want 1/6/0080/0", c, out_valid, out_shift, out_data[0], out_last); end
        end
        en = 1'b1;
        tick(1'b1, 16'h0001, 5'd3, 1'b0);
        total++; if (out_valid !== 1'b1 || out_shift !== 5'd2 || out_data[0] !== 16'h000C) begin bad++; $display("FAIL st_b2: got v=%b s=%0d d=%h want 1/2/000C", out_valid, out_shift, out_data[0]); end
        tick(1'b1, 16'h0001, 5'd9, 1'b0);
        total++; if (out_shift !== 5'd8 || out_data[0] !== 16'h0100 || out_last !== 1'b0) begin bad++; $display("FAIL st_b3: got s=%0d d=%h l=%b want 8/0100/0", out_shift, out_data[0], out_last); end
        tick(1'b0, 16'h0000, 5'd5, 1'b0);
        total++; if (out_shift !== 5'd4 || out_last !== 1'b1 || frame_shift_valid !== 1'b1 || frame_shift !== 5'd2) begin bad++; $display("FAIL st_b4: got s=%0d l=%b fv=%b fs=%0d want 4/1/1/2", out_shift, out_last, frame_shift_valid, frame_shift); end
        tick(1'b0, 16'h0000, 5'd0, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL st_nodup: got %b want 0", out_valid); end
    endtask

    task automatic test_frame_clr();
        tick(1'b0, 16'h0000, 5'd0, 1'b1);
        tick(1'b1, 16'h0001, 5'd0, 1'b0);
        tick(1'b1, 16'h0001, 5'd6, 1'b0);
        // Clear coincides with block 2 reaching the output stage
        tick(1'b1, 16'h0001, 5'd2, 1'b1);
        total++; if (out_valid !== 1'b1 || out_shift !== 5'd1 || out_last !== 1'b0 || frame_shift_valid !== 1'b0 || frame_shift !== 5'd2) begin bad++; $display("FAIL clr_blk: got v=%b s=%0d l=%b fv=%b fs=%0d want 1/1/0/0/2", out_valid, out_shift, out_last, frame_shift_valid, frame_shift); end
        tick(1'b1, 16'h0001, 5'd10, 1'b0);
        tick(1'b1, 16'h0001, 5'd8, 1'b0);
        tick(1'b1, 16'h0001, 5'd11, 1'b0);
        total++; if (out_shift !== 5'd10 || out_last !== 1'b0) begin bad++; $display("FAIL clr_n3: got s=%0d l=%b want 10/0", out_shift, out_last); end
        tick(1'b0, 16'h0000, 5'd9, 1'b0);
        total++; if (out_last !== 1'b1 || frame_shift_valid !== 1'b1 || frame_shift !== 5'd7) begin bad++; $display("FAIL clr_n4: got l=%b fv=%b fs=%0d want 1/1/7", out_last, frame_shift_valid, frame_shift); end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b1; frame_clr = 1'b0; in_valid = 1'b0; min_lzc = '0;
        for (int i = 0; i < 16; i++) in_data[i] = '0;
        test_reset();
        test_shift_math();
        test_sign();
        test_frame();
        test_stall();
        test_frame_clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
